// File: rtl/uart_tx_engine.sv
// UART transmit engine: word FIFO feeding a bit-timing FSM with runtime parity
// and stop-bit selection. Config is sampled per frame at the moment a word is popped.
module uart_tx_engine #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    output logic                              tx,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
    localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_push;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    assign in_ready    = (r_level < L_FULL);
    assign w_push      = in_valid && in_ready;
    assign w_bit_end   = (r_timer == T_LAST);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_cnt || !r_stop2);
    assign w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_last_stop);
    assign w_head      = r_mem[r_rd_ptr];

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign fifo_level  = r_level;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_stop2      <= 1'b0;
            r_stop_cnt   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands on the final stop cycle.
            r_frame_done <= (r_state == S_STOP) && (r_timer == T_PRE) && (r_stop_cnt || !r_stop2);
            if (w_pop) begin
                r_shift    <= w_head;
                r_par_en   <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
                r_par_bit  <= (^w_head) ^ (cfg_parity == 2'd2);
                r_stop2    <= cfg_stop2;
                r_state    <= S_START;
                r_timer    <= '0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_tx   <= 1'b1;
                r_busy <= 1'b0;
            end else begin
                r_timer <= w_bit_end ? '0 : r_timer + 1'b1;
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state   <= S_DATA;
                            r_tx      <= r_shift[0];
                            r_bit_cnt <= '0;
                        end
                        S_DATA: begin
                            if (r_bit_cnt == B_LAST) begin
                                r_stop_cnt <= 1'b0;
                                if (r_par_en) begin
                                    r_state <= S_PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= S_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            r_state    <= S_STOP;
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                        end
                        S_STOP: begin
                            if (!w_last_stop) begin
                                r_stop_cnt <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_tx    <= 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a line
// monitor rebuilds each frame from plain UART framing rules and compares per cycle.
module tb_uart_tx_engine;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] par;
        logic       s2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_level;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   starts[$];
    logic saw_full = 1'b0;

    uart_tx_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .busy(busy), .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, one or two stops.
    function automatic int build(input exp_t e, output logic [15:0] b);
        int n;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = e.d[i];
        n = 1 + DW;
        if (e.par == 2'd1) begin b[n] = ^e.d;  n++; end
        else if (e.par == 2'd2) begin b[n] = ~^e.d; n++; end
        b[n] = 1'b1; n++;
        if (e.s2) begin b[n] = 1'b1; n++; end
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready_vs_level", int'(in_ready), int'(fifo_level < DEPTH));
            if (fifo_level == 3'd4 && !in_ready) saw_full = 1'b1;
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [15:0] b;
        int          n, tx_bad, fd_bad, busy_bad;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    while (tx === 1'b0 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    n = build(e, b);
                    tx_bad = -1; fd_bad = -1; busy_bad = -1; aborted = 1'b0;
                    for (int i = 0; i < n * CPB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                        if (tx !== b[i / CPB] && tx_bad < 0) tx_bad = i;
                        if (frame_done !== (i == n * CPB - 1) && fd_bad < 0) fd_bad = i;
                        if (busy !== 1'b1 && busy_bad < 0) busy_bad = i;
                    end
                    if (!aborted) begin
                        chk($sformatf("frame_tx_first_bad_cycle d=%02h p=%0d s2=%0d", e.d, e.par, e.s2), tx_bad, -1);
                        chk($sformatf("frame_done_first_bad_cycle d=%02h", e.d), fd_bad, -1);
                        chk($sformatf("frame_busy_first_bad_cycle d=%02h", e.d), busy_bad, -1);
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        chk("push_accept", int'(in_ready), 1);
        e.d = d; e.par = cfg_parity; e.s2 = cfg_stop2;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (n < 3000 && (exp_q.size() != 0 || busy || fifo_level != 0)) begin
            @(negedge clk); n++;
        end
        chk("drain_complete", int'(exp_q.size() == 0 && !busy && fifo_level == 0), 1);
        @(negedge clk);
    endtask

    initial begin : stim
        exp_t e;
        int   n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5, 8N1, with first-word latency
        in_valid = 1'b1; in_data = 8'hA5;
        e.d = 8'hA5; e.par = 2'd0; e.s2 = 1'b0; exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_level_n1", int'(fifo_level), 1);
        chk("lat_tx_n1", int'(tx), 1);
        @(negedge clk);
        chk("lat_level_n2", int'(fifo_level), 0);
        chk("lat_tx_n2", int'(tx), 0);
        chk("lat_busy_n2", int'(busy), 1);
        drain();
        chk("idle_tx_high", int'(tx), 1);

        // even / odd parity
        cfg_parity = 2'd1; push_word(8'h07); in_valid = 1'b0; drain();
        cfg_parity = 2'd2; push_word(8'h07); in_valid = 1'b0; drain();

        // two stop bits
        cfg_parity = 2'd0; cfg_stop2 = 1'b1; push_word(8'h00); in_valid = 1'b0; drain();
        cfg_stop2 = 1'b0;

        // six words with valid held, contiguous frames
        starts.delete(); saw_full = 1'b0;
        for (int k = 0; k < 6; k++) push_word(8'($urandom));
        in_valid = 1'b0;
        drain();
        chk("burst_saw_full", int'(saw_full), 1);
        chk("burst_frames", starts.size(), 6);
        for (int i = 1; i < starts.size(); i++)
            chk($sformatf("burst_gap_%0d", i), starts[i] - starts[i-1], 10 * CPB);

        // parity enabled mid-frame applies only to the next frame
        cfg_parity = 2'd0; push_word(8'h5A); in_valid = 1'b0;
        repeat (10) @(negedge clk);
        cfg_parity = 2'd1; push_word(8'hC3); in_valid = 1'b0;
        drain();
        cfg_parity = 2'd0;

        // reset in the middle of DATA with two words queued
        push_word(8'h11); push_word(8'h22); push_word(8'h33); in_valid = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        repeat (3 * CPB) @(negedge clk);
        chk("pre_rst_level", int'(fifo_level), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_frame_done", int'(frame_done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        push_word(8'h3C); in_valid = 1'b0; drain();

        // randomized batches, config constant per batch
        for (int bt = 0; bt < 8; bt++) begin
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop2  = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                push_word(8'($urandom));
                if ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                end
            end
            in_valid = 1'b0;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine that replaces the fixed 8N1 driver-BFM transmit path. Bytes (words) enter through a valid/ready push port into an internal FIFO. A bit-timing FSM serialises each word onto tx with runtime-selectable parity and stop-bit count. It sits between the driver proxy's stimulus path and the DUT serial input, and also serves as synthesizable TX for loopback benches.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, word FIFO depth; power of 2, >=2.
CLKS_PER_BIT, 16, clk cycles per serial bit; >=2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  push request
in_ready  output  1  FIFO can accept a word
in_data  input  DATA_W  word to transmit, LSB sent first
cfg_parity  input  2  0=none, 1=even, 2=odd, 3=none
cfg_stop2  input  1  0=one stop bit, 1=two stop bits
tx  output  1  serial line, idle high
busy  output  1  high while FSM is not IDLE
frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit
fifo_level  output  $clog2(FIFO_DEPTH+1)  words currently stored

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, frame_done=0, fifo_level=0, in_ready=1. FIFO pointers cleared, FSM=IDLE, counters=0. Reset mid-frame aborts the frame; tx returns high immediately and no frame_done is issued.
- Push: word accepted on a cycle where in_valid && in_ready. in_ready = (fifo_level < FIFO_DEPTH). When full, in_ready=0 even if a pop happens in the same cycle; no combinational ready-from-pop path.
- Simultaneous push and pop: fifo_level unchanged, both operations take effect.
- FIFO pointers wrap modulo FIFO_DEPTH; order is strictly FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_level>0, pop the head word into the shift register. Latch cfg_parity and cfg_stop2 into shadow registers. Next state is START.
- Each bit state holds tx for exactly CLKS_PER_BIT cycles, timed by a bit-timer counting 0..CLKS_PER_BIT-1.
- START: tx=0, then DATA.
- DATA: tx=shift[0]; shift right after each bit. After DATA_W bits go to PARITY if parity is enabled, else STOP.
- PARITY: tx = XOR of all data bits for even parity, inverted XOR for odd parity.
- STOP: tx=1 for 1 or 2 bit times per the latched stop count. frame_done=1 in the final cycle of the last stop bit.
- Back-to-back frames: in that final STOP cycle, if fifo_level>0, pop and latch config, then go directly to START with no idle gap. Otherwise go to IDLE.
- Config changes during a frame have no effect until the next frame's latch point.
- Latency: a push into an empty FIFO with the FSM idle at cycle N gives fifo_level=1 at N+1, pop at N+1, and tx=0 from N+2.
- Frame length: (1 + DATA_W + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 (parity bit) and S is 1 or 2 (stop bits).
- busy=1 from START entry through the last STOP cycle.

Test Plan:
1. CLKS_PER_BIT=4, DATA_W=8, no parity, stop1; push 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; frame_done single pulse in cycle 40; tx high afterwards.
2. cfg_parity=1 with 0x07 -> parity bit 1. cfg_parity=2 with 0x07 -> parity bit 0. Frame is 11 bit-times.
3. cfg_stop2=1, no parity, 0x00 -> tx low for 9 bit-times, then high for 2 bit-times; frame is 44 cycles at CLKS_PER_BIT=4.
4. in_valid held high with 6 words while idle, FIFO_DEPTH=4 -> first word popped, in_ready drops once fifo_level=4; frames follow contiguously with no tx-high gap between the stop bit and the next start bit; transmission order matches push order.
5. Change cfg_parity from 0 to 1 mid-frame -> current frame has no parity bit; next frame includes it.
6. Assert rst_n low in the middle of DATA bits with 2 words queued -> tx=1 immediately, fifo_level=0, busy=0, no frame_done; after release, the next push transmits normally.
